// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared types and defaults for the DCO frequency detector
package pll_pkg;

  localparam int CNT_W_DEF = 10;
  localparam int PH_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    STROBE = 2'd2
  } state_t;

  // Encoded directly as {p_up, p_down}; both low is never a legal result.
  typedef enum logic [1:0] {
    CMP_SLOW = 2'b01,
    CMP_FAST = 2'b10,
    CMP_HOLD = 2'b11
  } cmp_t;

endpackage

// File: rtl/ref_edge_sync.sv
// rtl/ref_edge_sync.sv - two-flop synchroniser with a one-cycle rising-edge pulse
module ref_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/dco_freq_detector.sv
// rtl/dco_freq_detector.sv - counts dco_clk cycles per ref_clk period and issues up/down strobes
module dco_freq_detector
  import pll_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEADBAND = 1,
  parameter int PH       = PH_DEF
) (
  input  logic             dco_clk,
  input  logic             reset_n,
  input  logic             ref_clk,
  input  logic [CNT_W-1:0] mult_n,
  output logic             phase_clk,
  output logic             p_up,
  output logic             p_down,
  output logic [CNT_W-1:0] count_out,
  output logic             ovf,
  output logic             err_overlap
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   DB_X    = (CNT_W+1)'(DEADBAND);
  localparam logic [3:0]       PH_LAST = 4'(PH - 1);

  state_t           state, state_nx;
  logic             rise;
  logic [CNT_W-1:0] cnt, mult_q;
  logic             sat;
  logic [3:0]       ph_cnt;
  logic             do_cmp, overlap;
  logic [CNT_W:0]   cnt_x, mult_x, lo, hi;
  cmp_t             cmp;

  ref_edge_sync u_sync (
    .clk      (dco_clk),
    .rst_n    (reset_n),
    .async_in (ref_clk),
    .rise     (rise)
  );

  // The strobe lasts one cycle past STROBE (phase_clk is registered), so an edge
  // landing in that trailing high cycle is treated as an overlap as well.
  assign do_cmp  = rise && (state == COUNT) && !phase_clk;
  assign overlap = rise && ((state == STROBE) || ((state == COUNT) && phase_clk));

  always_comb begin
    cnt_x  = {1'b0, cnt};
    mult_x = {1'b0, mult_q};
    hi     = mult_x + DB_X;
    lo     = (mult_x >= DB_X) ? (mult_x - DB_X) : '0;
    if (sat || (cnt_x > hi)) cmp = CMP_FAST;
    else if (cnt_x < lo)     cmp = CMP_SLOW;
    else                     cmp = CMP_HOLD;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise) state_nx = COUNT;
      COUNT:   if (do_cmp) state_nx = STROBE;
      STROBE:  if (ph_cnt == PH_LAST) state_nx = COUNT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sat         <= 1'b0;
      mult_q      <= '0;
      ph_cnt      <= '0;
      phase_clk   <= 1'b0;
      p_up        <= 1'b1;
      p_down      <= 1'b1;
      count_out   <= '0;
      ovf         <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      state     <= state_nx;
      phase_clk <= (state == STROBE);
      ph_cnt    <= (state == STROBE) ? ph_cnt + 4'd1 : 4'd0;
      if (rise) begin
        cnt    <= CNT_ONE;
        sat    <= 1'b0;
        mult_q <= mult_n;
        if (state != IDLE) begin
          count_out <= cnt;
          ovf       <= sat;
        end
        if (do_cmp)  {p_up, p_down} <= cmp;
        if (overlap) err_overlap <= 1'b1;
      end else if (state != IDLE) begin
        if (cnt == CNT_MAX) sat <= 1'b1;
        else                cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/dco_freq_detector.md
DCO_FREQ_DETECTOR -- requirements
Module: dco_freq_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 10, width of window counter and mult_n.
REQ-002 SHALL have parameter DEADBAND, default 1, lock tolerance in dco_clk cycles.
REQ-003 SHALL have parameter PH, default 4, phase_clk high width in dco_clk cycles (2..8).
REQ-004 SHALL have port dco_clk  input  1  the single clock (DCO output); all flops on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ref_clk  input  1  reference clock, asynchronous to dco_clk.
REQ-007 SHALL have port mult_n  input  CNT_W  target DCO cycles per reference period.
REQ-008 SHALL have port phase_clk  output  1  update strobe for the PLL controller, which samples on its falling edge.
REQ-009 SHALL have port p_up  output  1  active-low "DCO slow, raise code".
REQ-010 SHALL have port p_down  output  1  active-low "DCO fast, lower code".
REQ-011 SHALL have port count_out  output  CNT_W  last completed window count.
REQ-012 SHALL have port ovf  output  1  last window saturated.
REQ-013 SHALL have port err_overlap  output  1  sticky; a ref edge arrived during phase_clk high.

Function
REQ-014 SHALL synchronise ref_clk through 2 flops plus an edge register; ref_rise pulses 1 cycle, 3 dco_clk cycles after the ref_clk rising edge.
REQ-015 SHALL implement FSM IDLE, COUNT, STROBE.
REQ-016 IDLE: on ref_rise, set counter=1, latch mult_n, go to COUNT; make no comparison.
REQ-017 COUNT: increment the counter each cycle, saturating at 2^CNT_W-1 and setting internal sat.
REQ-018 Window count SHALL equal the cycle distance between consecutive ref_rise pulses; a 100-cycle ref period yields 100.
REQ-019 On ref_rise in COUNT: latch count_out and ovf=sat; restart counter=1, clear sat, re-latch mult_n in the same cycle.
REQ-020 Compare in CNT_W+1 bits without wrap: count < mult_n-DEADBAND gives p_up=0,p_down=1; count > mult_n+DEADBAND or sat gives p_up=1,p_down=0; otherwise both 1.
REQ-021 A lower bound below 0 SHALL clamp to 0.
REQ-022 p_up/p_down SHALL update in cycle E+1 (E = ref_rise cycle), are never both 0, and hold until the next update.
REQ-023 phase_clk SHALL rise at E+2 and stay high PH cycles (FSM STROBE), then return low and go to COUNT; p_up/p_down are stable across its falling edge.
REQ-024 The counter SHALL keep running during STROBE.
REQ-025 A ref_rise during STROBE SHALL restart the window and update count_out, drop that comparison (no output change, no pulse extension), and set err_overlap.
REQ-026 err_overlap SHALL clear only on reset.

Reset
REQ-027 While reset_n=0: phase_clk=0, p_up=1, p_down=1, count_out=0, ovf=0, err_overlap=0, sync flops 0, FSM=IDLE.
REQ-028 Deassertion mid-window SHALL discard the partial count; the first ref_rise after reset produces no strobe.

Structure
REQ-029 Package pll_pkg SHALL hold the state enum, CNT_W/PH defaults, and the compare-result encoding.
REQ-030 Sub-module ref_edge_sync (2-flop synchroniser + rising-edge pulse) SHALL be separate.

Verification (mult_n=100, DEADBAND=1, PH=4)
REQ-031 Ref period 100 dco cycles: after the second edge, count_out=100, p_up=p_down=1, 4-cycle phase_clk pulse each period.
REQ-032 Ref period 90: count_out=90, p_up=0, p_down=1 at E+1, phase_clk high E+2..E+5.
REQ-033 Ref period 110: count_out=110, p_down=0, p_up=1; period 99 or 101 gives both 1.
REQ-034 ref_clk held low 1500 cycles then edge: count_out=1023, ovf=1, p_down=0.
REQ-035 Edges 3 cycles apart (inside STROBE): err_overlap=1, outputs unchanged, no second pulse.
REQ-036 reset_n low mid-window at count 50: all outputs reset immediately; after release, the first edge gives no strobe and the second edge gives a valid result.
